// File: rtl/tx_pll_ctrl.sv
// Reset and lock sequencer for the LVDS transmit PLL: it pulses the PLL reset,
// waits for a debounced lock, retries on timeout and releases the TX datapath.
module tx_pll_ctrl #(
  parameter int unsigned C_RST_HOLD     = 200,
  parameter int unsigned C_LOCK_STABLE  = 64,
  parameter int unsigned C_LOCK_TIMEOUT = 4096,
  parameter int unsigned C_MAX_RETRY    = 7
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_pll_lock,
  input  logic       I_soft_rst,
  output logic       O_pll_rst,
  output logic       O_tx_rst,
  output logic       O_ready,
  output logic       O_fail,
  output logic [3:0] O_retry_cnt,
  output logic [2:0] O_state
);

  localparam int unsigned C_MAX_A = (C_RST_HOLD > C_LOCK_STABLE) ? C_RST_HOLD : C_LOCK_STABLE;
  localparam int unsigned C_MAX_P = (C_MAX_A > C_LOCK_TIMEOUT) ? C_MAX_A : C_LOCK_TIMEOUT;
  localparam int          CW      = $clog2(C_MAX_P + 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d, retry_inc;
  logic            sync1_q, lock_s_q;
  logic            pll_rst_q, tx_rst_q, ready_q, fail_q;

  assign retry_inc = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;

  // One shared counter; it is cleared on every state change so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    case (state_q)
      ST_RESET: begin
        if (cnt_q == CW'(C_RST_HOLD - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(C_LOCK_TIMEOUT - 1)) begin
          retry_d = retry_inc;
          state_d = (retry_inc == 4'(C_MAX_RETRY)) ? ST_FAIL : ST_RESET;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(C_LOCK_STABLE - 1)) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s_q) state_d = ST_RESET;
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
    // Soft restart overrides whatever transition was computed above.
    if (I_soft_rst) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = 4'd0;
    end
  end

  // Outputs are decoded from the next state so they line up with O_state.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      pll_rst_q <= 1'b1;
      tx_rst_q  <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      sync1_q   <= I_pll_lock;
      lock_s_q  <= sync1_q;
      pll_rst_q <= (state_d == ST_RESET);
      tx_rst_q  <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign O_pll_rst   = pll_rst_q;
  assign O_tx_rst    = tx_rst_q;
  assign O_ready     = ready_q;
  assign O_fail      = fail_q;
  assign O_retry_cnt = retry_q;
  assign O_state     = state_q;

endmodule

// File: doc/tx_pll_ctrl.md
Name: tx_pll_ctrl

Overview:
- Reset and lock sequencer for the LVDS transmit PLL.
- Holds the TX PLL in reset for a fixed time after power-up, then waits for lock and debounces it.
- Retries the PLL on lock timeout and declares failure after a set number of retries.
- Releases O_tx_rst only after lock has been stable. O_tx_rst feeds the receive-side clocking's I_tx_rst and the TX datapath.

Parameters:
- C_RST_HOLD, 200: cycles O_pll_rst is held high on each PLL reset attempt.
- C_LOCK_STABLE, 64: consecutive cycles of synchronized lock required before release.
- C_LOCK_TIMEOUT, 4096: cycles allowed in ST_WAIT_LOCK before a retry.
- C_MAX_RETRY, 7: lock timeouts tolerated before ST_FAIL (1..15).

Ports:
- I_clk, input, 1: reference clock, the PLL refclk domain.
- I_rst_n, input, 1: asynchronous active-low reset.
- I_pll_lock, input, 1: PLL lock, asynchronous to I_clk.
- I_soft_rst, input, 1: synchronous single-cycle request to restart the sequence.
- O_pll_rst, output, 1: active-high reset to the PLL pllreset pin.
- O_tx_rst, output, 1: active-high reset for the TX datapath / I_tx_rst.
- O_ready, output, 1: high while in ST_RUN.
- O_fail, output, 1: high while in ST_FAIL.
- O_retry_cnt, output, 4: timeouts since the last success or restart.
- O_state, output, 3: current state encoding, for debug.

Behaviour:
- Reset values (I_rst_n low, asynchronous):
  - state = ST_RESET
  - O_pll_rst = 1, O_tx_rst = 1
  - O_ready = 0, O_fail = 0
  - O_retry_cnt = 0
  - all counters 0, synchronizer flops 0
- All outputs are registered.
- I_pll_lock passes through a 2-flop synchronizer to lock_s. Lock edge to lock_s takes 2 cycles.
- State encodings: ST_RESET = 0, ST_WAIT_LOCK = 1, ST_STABLE = 2, ST_RUN = 3, ST_FAIL = 4.
- ST_RESET:
  - O_pll_rst = 1, O_tx_rst = 1.
  - Counter runs 0..C_RST_HOLD-1, then goes to ST_WAIT_LOCK. O_pll_rst is high for exactly C_RST_HOLD cycles per entry.
- ST_WAIT_LOCK:
  - O_pll_rst = 0. The timeout counter starts at 0 on entry.
  - lock_s = 1: go to ST_STABLE.
  - Else, counter reaches C_LOCK_TIMEOUT-1: increment retry count. If the new value equals C_MAX_RETRY, go to ST_FAIL; else go to ST_RESET.
  - lock_s = 1 in the same cycle as timeout expiry: lock wins, no retry is counted.
- ST_STABLE:
  - Counts consecutive cycles with lock_s = 1.
  - lock_s = 0: go to ST_WAIT_LOCK with the timeout counter restarted. No retry is counted.
  - Count reaches C_LOCK_STABLE: go to ST_RUN and clear the retry count.
- ST_RUN:
  - O_tx_rst = 0, O_ready = 1.
  - O_tx_rst falls in the same cycle O_ready rises, i.e. the first cycle O_state = 3.
  - lock_s = 0 for any single cycle: go to ST_RESET. O_tx_rst = 1 and O_ready = 0 from the next cycle. No retry is counted.
- ST_FAIL:
  - O_pll_rst = 0, O_tx_rst = 1, O_fail = 1.
  - Sticky until I_soft_rst or I_rst_n.
- I_soft_rst:
  - Highest priority in every state, including in the same cycle as any other transition.
  - Forces ST_RESET, clears the retry count and all counters, and sets O_pll_rst = 1 next cycle.
- O_retry_cnt saturates at 15 and never wraps.
- Counter widths: sized to the largest parameter. No wrap is possible, because every counter is cleared on state entry.
- I_pll_lock glitches while in ST_RESET are ignored.

Test Plan:
All scenarios use C_RST_HOLD=8, C_LOCK_STABLE=4, C_LOCK_TIMEOUT=32, C_MAX_RETRY=3.
1. Release I_rst_n, then raise lock at cycle 20 -> O_pll_rst high for cycles 0-7. O_state goes 1 -> 2 at cycle 22. O_tx_rst falls and O_ready rises at cycle 26. O_retry_cnt = 0.
2. Keep lock low -> three full 8-cycle reset pulses separated by 32-cycle waits. O_retry_cnt steps 1, 2, 3. Then O_state = 4 and O_fail = 1, and O_pll_rst stays 0 indefinitely.
3. In ST_STABLE, drop lock after 2 cycles -> return to ST_WAIT_LOCK and O_retry_cnt is unchanged. Relock held 4 cycles -> ST_RUN.
4. In ST_RUN, apply a 1-cycle lock low pulse -> O_ready = 0, O_tx_rst = 1, O_state = 0. A new 8-cycle O_pll_rst pulse follows.
5. In ST_FAIL, pulse I_soft_rst -> O_fail = 0, O_retry_cnt = 0, O_pll_rst = 1 next cycle, and the sequence restarts. Repeat with I_soft_rst coinciding with a timeout -> soft reset wins.
6. Lock rises in the exact cycle the timeout counter hits 31 -> ST_STABLE is entered and O_retry_cnt is unchanged. Also assert I_rst_n mid-ST_STABLE -> all outputs take their reset values immediately.
